dpe_multiplexer: RTL and testbench

DPE_MULTIPLEXER -- requirements
Module: dpe_multiplexer

---
 rtl/dpe_pkg.sv | 16 +
 rtl/dpe_if.sv | 28 ++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/dpe_multiplexer.sv | 138 +++++++++++++
 tb/tb_dpe_multiplexer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/dpe_pkg.sv
// Shared widths, input count and types for the DPE packet multiplexer.
package dpe_pkg;

    localparam int DPE_DATA_W = 128;
    localparam int DPE_KEEP_W = DPE_DATA_W / 8;
    localparam int NUM_INPUTS = 5;
    localparam int SRC_IDX_W  = $clog2(NUM_INPUTS);

    typedef logic [SRC_IDX_W-1:0] src_idx_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } dpe_state_e;

endpackage

// File: rtl/dpe_if.sv
// AXI-Stream style packet bundle; clock and reset travel with the bundle.
interface dpe_if
    import dpe_pkg::*;
#(
    parameter int DATA_W = DPE_DATA_W,
    parameter int KEEP_W = DATA_W / 8
) (
    input logic clk,
    input logic rst
);

    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [KEEP_W-1:0] tkeep;
    logic [DATA_W-1:0] tdata;

    modport sink (
        input  clk, rst, tvalid, tlast, tkeep, tdata,
        output tready
    );

    modport source (
        input  clk, rst, tready,
        output tvalid, tlast, tkeep, tdata
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from the input after the last-served one.
module rr_arbiter #(
    parameter int N     = 5,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     i_req,
    input  logic             i_update,
    input  logic [IDX_W-1:0] i_update_idx,
    output logic             o_valid,
    output logic [N-1:0]     o_grant_oh,
    output logic [IDX_W-1:0] o_grant_idx
);

    logic [IDX_W-1:0] r_last;
    logic             w_found;
    logic [IDX_W-1:0] w_idx;

    function automatic logic [IDX_W-1:0] f_wrap(input logic [IDX_W-1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= N) begin
            sum = sum - N;
        end
        return IDX_W'(sum);
    endfunction

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            if (!w_found && i_req[f_wrap(r_last, k)]) begin
                w_found = 1'b1;
                w_idx   = f_wrap(r_last, k);
            end
        end
    end

    assign o_valid     = w_found;
    assign o_grant_idx = w_idx;
    assign o_grant_oh  = w_found ? (N'(1) << w_idx) : '0;

    // Reset points at the last input so input 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last <= IDX_W'(N - 1);
        end else if (i_update) begin
            r_last <= i_update_idx;
        end
    end

endmodule

// File: rtl/dpe_multiplexer.sv
// Packet-granular 5:1 stream merger; the owning input streams straight through to to_dpe.
//   state | meaning
//   IDLE  | no owner; arbitrate unless paused
//   BUSY  | r_grant owns to_dpe until its tlast handshake
module dpe_multiplexer
    import dpe_pkg::*;
#(
    parameter int DATA_W = DPE_DATA_W,
    parameter int KEEP_W = DATA_W / 8
) (
    dpe_if.sink   from_cpu,
    dpe_if.sink   from_eth_1,
    dpe_if.sink   from_eth_2,
    dpe_if.sink   from_eth_3,
    dpe_if.sink   from_eth_4,
    dpe_if.source to_dpe,
    input  logic  pause,
    output logic  is_idle
);

    logic                  w_clk;
    logic                  w_rst;
    logic [NUM_INPUTS-1:0] w_in_valid;
    logic [NUM_INPUTS-1:0] w_in_last;
    logic [NUM_INPUTS-1:0] w_in_ready;
    logic [DATA_W-1:0]     w_in_data [NUM_INPUTS];
    logic [KEEP_W-1:0]     w_in_keep [NUM_INPUTS];

    logic                  w_out_valid;
    logic                  w_out_last;
    logic [DATA_W-1:0]     w_out_data;
    logic [KEEP_W-1:0]     w_out_keep;
    logic                  w_pkt_end;

    logic [NUM_INPUTS-1:0] w_arb_req;
    logic                  w_arb_valid;
    logic [NUM_INPUTS-1:0] w_arb_oh;
    src_idx_t              w_arb_idx;

    dpe_state_e            r_state;
    src_idx_t              r_grant;
    logic [NUM_INPUTS-1:0] r_grant_oh;
    logic                  r_is_idle;

    assign w_clk = to_dpe.clk;
    assign w_rst = to_dpe.rst;

    assign w_in_valid = {from_eth_4.tvalid, from_eth_3.tvalid, from_eth_2.tvalid,
                         from_eth_1.tvalid, from_cpu.tvalid};
    assign w_in_last  = {from_eth_4.tlast, from_eth_3.tlast, from_eth_2.tlast,
                         from_eth_1.tlast, from_cpu.tlast};
    assign w_in_data[0] = from_cpu.tdata;
    assign w_in_data[1] = from_eth_1.tdata;
    assign w_in_data[2] = from_eth_2.tdata;
    assign w_in_data[3] = from_eth_3.tdata;
    assign w_in_data[4] = from_eth_4.tdata;
    assign w_in_keep[0] = from_cpu.tkeep;
    assign w_in_keep[1] = from_eth_1.tkeep;
    assign w_in_keep[2] = from_eth_2.tkeep;
    assign w_in_keep[3] = from_eth_3.tkeep;
    assign w_in_keep[4] = from_eth_4.tkeep;

    always_comb begin
        w_out_valid = 1'b0;
        w_out_last  = 1'b0;
        w_out_data  = '0;
        w_out_keep  = '0;
        if (r_state == ST_BUSY) begin
            w_out_valid = w_in_valid[r_grant];
            w_out_last  = w_in_last[r_grant];
            w_out_data  = w_in_data[r_grant];
            w_out_keep  = w_in_keep[r_grant];
        end
    end

    // Backpressure reaches only the owner; everyone else sees tready low.
    assign w_in_ready = (r_state == ST_BUSY && to_dpe.tready) ? r_grant_oh : '0;
    assign w_pkt_end  = w_out_valid && to_dpe.tready && w_out_last;
    assign w_arb_req  = (r_state == ST_IDLE && !pause) ? w_in_valid : '0;

    assign to_dpe.tvalid    = w_out_valid;
    assign to_dpe.tlast     = w_out_last;
    assign to_dpe.tdata     = w_out_data;
    assign to_dpe.tkeep     = w_out_keep;
    assign from_cpu.tready   = w_in_ready[0];
    assign from_eth_1.tready = w_in_ready[1];
    assign from_eth_2.tready = w_in_ready[2];
    assign from_eth_3.tready = w_in_ready[3];
    assign from_eth_4.tready = w_in_ready[4];
    assign is_idle           = r_is_idle;

    rr_arbiter #(
        .N     (NUM_INPUTS),
        .IDX_W (SRC_IDX_W)
    ) u_rr_arbiter (
        .clk          (w_clk),
        .rst          (w_rst),
        .i_req        (w_arb_req),
        .i_update     (w_pkt_end),
        .i_update_idx (r_grant),
        .o_valid      (w_arb_valid),
        .o_grant_oh   (w_arb_oh),
        .o_grant_idx  (w_arb_idx)
    );

    always_ff @(posedge w_clk) begin
        if (!w_rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_grant_oh <= '0;
            r_is_idle  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_state    <= ST_BUSY;
                        r_grant    <= w_arb_idx;
                        r_grant_oh <= w_arb_oh;
                        r_is_idle  <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (w_pkt_end) begin
                        r_state    <= ST_IDLE;
                        r_grant_oh <= '0;
                        r_is_idle  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_grant_oh <= '0;
                    r_is_idle  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dpe_multiplexer.sv
// Directed bench for dpe_multiplexer: round robin, backpressure, pause, re-grant and reset.
module tb_dpe_multiplexer;
    import dpe_pkg::*;

    localparam int DW = DPE_DATA_W;
    localparam int KW = DPE_KEEP_W;
    localparam int N  = NUM_INPUTS;
    localparam int TOTAL_WORDS = 23;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pause = 1'b0;
    logic dst_ready = 1'b0;
    logic is_idle;
    logic [N-1:0] src_en = '0;
    logic [N-1:0] w_rdy;

    int pkt_len [N] = '{6, 4, 5, 4, 4};
    int base    [N] = '{1, 11, 21, 31, 41};
    int src_npkt[N] = '{1, 1, 1, 1, 1};

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int viol = 0;

    logic [DW-1:0] q_data[$];
    logic          q_last[$];
    logic [KW-1:0] q_keep[$];
    int            q_cyc[$];

    always #5 clk = ~clk;

    dpe_if #(.DATA_W(DW), .KEEP_W(KW)) u_src [N] (.clk(clk), .rst(rst));
    dpe_if #(.DATA_W(DW), .KEEP_W(KW)) u_dst (.clk(clk), .rst(rst));

    dpe_multiplexer #(.DATA_W(DW), .KEEP_W(KW)) dut (
        .from_cpu   (u_src[0]),
        .from_eth_1 (u_src[1]),
        .from_eth_2 (u_src[2]),
        .from_eth_3 (u_src[3]),
        .from_eth_4 (u_src[4]),
        .to_dpe     (u_dst),
        .pause      (pause),
        .is_idle    (is_idle)
    );

    assign u_dst.tready = dst_ready;

    // Each source emits src_npkt packets of base..base+len-1; pointer clears while disabled.
    for (genvar g = 0; g < N; g++) begin : g_src
        int ptr;
        assign u_src[g].tvalid = src_en[g] && (ptr < pkt_len[g] * src_npkt[g]);
        assign u_src[g].tlast  = ((ptr + 1) % pkt_len[g]) == 0;
        assign u_src[g].tdata  = DW'(base[g] + (ptr % pkt_len[g]));
        assign u_src[g].tkeep  = u_src[g].tlast ? KW'(16'h0FFF) : '1;
        assign w_rdy[g]        = u_src[g].tready;
        always @(posedge clk) begin
            if (!src_en[g]) begin
                ptr <= 0;
            end else if (u_src[g].tvalid && u_src[g].tready) begin
                ptr <= ptr + 1;
            end
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst && u_dst.tvalid && u_dst.tready) begin
            q_data.push_back(u_dst.tdata);
            q_last.push_back(u_dst.tlast);
            q_keep.push_back(u_dst.tkeep);
            q_cyc.push_back(cyc);
        end
        viol <= viol + (($countones(w_rdy) > 1) ? 1 : 0) + ((is_idle && u_dst.tvalid) ? 1 : 0);
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        q_data.delete();
        q_last.delete();
        q_keep.delete();
        q_cyc.delete();
    endtask

    task automatic wait_xfers(input int n, input int budget, input string tag);
        int i = 0;
        while (q_data.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(tag, DW'(q_data.size()), DW'(n));
    endtask

    task automatic check_seq(input string tag);
        int idx = 0;
        chk($sformatf("%s_count", tag), DW'(q_data.size()), DW'(TOTAL_WORDS));
        for (int s = 0; s < N; s++) begin
            for (int k = 0; k < pkt_len[s]; k++) begin
                if (idx < q_data.size()) begin
                    chk($sformatf("%s_data%0d", tag, idx), q_data[idx], DW'(base[s] + k));
                    chk($sformatf("%s_last%0d", tag, idx), DW'(q_last[idx]), DW'(k == pkt_len[s] - 1));
                end
                idx++;
            end
        end
    endtask

    task automatic idle_sources();
        src_en = '0;
        repeat (2) @(negedge clk);
        clear_log();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with every source requesting: nothing may be granted.
        rst = 1'b0;
        src_en = '1;
        dst_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_is_idle", DW'(is_idle), DW'(1));
        chk("rst_tvalid", DW'(u_dst.tvalid), DW'(0));
        chk("rst_tready", DW'(w_rdy), DW'(0));
        src_en = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", DW'(is_idle), DW'(1));

        // All five request together, no backpressure.
        clear_log();
        src_en = '1;
        wait_xfers(TOTAL_WORDS, 300, "rr_wait");
        check_seq("rr");
        if (q_data.size() >= TOTAL_WORDS) begin
            chk("rr_gap", DW'(q_cyc[6] - q_cyc[5]), DW'(2));
            chk("rr_stream", DW'(q_cyc[1] - q_cyc[0]), DW'(1));
            chk("rr_keep_mid", DW'(q_keep[0]), DW'(16'hFFFF));
            chk("rr_keep_last", DW'(q_keep[5]), DW'(16'h0FFF));
        end
        repeat (5) @(negedge clk);
        chk("rr_no_dup", DW'(q_data.size()), DW'(TOTAL_WORDS));
        chk("rr_idle_end", DW'(is_idle), DW'(1));
        idle_sources();

        // Same traffic with short tready-low windows.
        src_en = '1;
        for (int i = 0; i < 400 && q_data.size() < TOTAL_WORDS; i++) begin
            @(negedge clk);
            dst_ready = !((i % 7 == 3) || (i % 7 == 4) || (i % 5 == 1));
        end
        dst_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_seq("bp");
        idle_sources();

        // Pause mid-packet: cpu finishes, nothing else starts until release.
        src_en = '1;
        wait_xfers(2, 50, "pause_start");
        pause = 1'b1;
        repeat (20) @(negedge clk);
        chk("pause_count", DW'(q_data.size()), DW'(6));
        chk("pause_idle", DW'(is_idle), DW'(1));
        chk("pause_tvalid", DW'(u_dst.tvalid), DW'(0));
        chk("pause_tready", DW'(w_rdy), DW'(0));
        pause = 1'b0;
        wait_xfers(TOTAL_WORDS, 300, "pause_resume");
        check_seq("pause");
        idle_sources();

        // Only eth_3 with two back-to-back packets: re-granted after one idle cycle.
        src_npkt[3] = 2;
        src_en = 5'b01000;
        wait_xfers(8, 100, "solo_wait");
        if (q_data.size() >= 8) begin
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("solo_data%0d", k), q_data[k], DW'(31 + (k % 4)));
                chk($sformatf("solo_last%0d", k), DW'(q_last[k]), DW'(k % 4 == 3));
            end
            chk("solo_gap", DW'(q_cyc[4] - q_cyc[3]), DW'(2));
        end
        idle_sources();
        src_npkt[3] = 1;

        // Reset mid-packet: last served is eth_3, so eth_4 owns the bus when reset hits.
        src_en = '1;
        wait_xfers(3, 50, "rstmid_start");
        if (q_data.size() >= 1) begin
            chk("rstmid_owner", q_data[0], DW'(41));
        end
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_tvalid", DW'(u_dst.tvalid), DW'(0));
        chk("rstmid_tready", DW'(w_rdy), DW'(0));
        chk("rstmid_idle", DW'(is_idle), DW'(1));
        src_en = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_log();
        src_en = 5'b10001;
        wait_xfers(10, 100, "rstmid_after");
        if (q_data.size() >= 10) begin
            for (int k = 0; k < 6; k++) begin
                chk($sformatf("rstmid_cpu%0d", k), q_data[k], DW'(1 + k));
            end
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("rstmid_eth4_%0d", k), q_data[6 + k], DW'(41 + k));
            end
        end
        src_en = '0;
        repeat (3) @(negedge clk);

        chk("protocol_violations", DW'(viol), DW'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
